execute_stage: RTL and testbench
================================

# execute_stage

Execute/memory/write-back stage that consumes the 12-bit `ctrl_ex` bundle produced by instruction decode. It performs ALU ops (ADD/SUB/AND/OR), iterative MUL, and LW/SW memory accesses, then emits a one-cycle register-file write-back pulse. It sits between decode/register-read and the register file, with a valid/ready handshake toward decode and a req/ack handshake toward data memory.

## Interface
- `MUL_BITS_PER_CYCLE`, default 4: multiplier bits retired per cycle; must divide 32. `MUL_ITERS = 32/MUL_BITS_PER_CYCLE`.
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: decode presents an instruction.
- `in_ready` out 1: stage accepts this cycle.
- `ctrl_ex` in 12: {c_sel[11], d_sel[10], op_sel[9:8], wr_rd[7], wb_sel[6], write_back_en[5], write_back_reg[4:0]}.
- `a_data` in 32: value of register a.
- `b_data` in 32: value of register b.
- `imm` in 32: sign-extended immediate.
- `mem_req` out 1: memory request.
- `mem_we` out 1: 1 = write.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: store data.
- `mem_ack` in 1: request completed.
- `mem_rdata` in 32: load data, valid with `mem_ack`.
- `wb_en` out 1: one-cycle write-back strobe.
- `wb_reg` out 5: destination register.
- `wb_data` out 32: write-back value.

## Operation
- Operand B is `imm` when c_sel=1, else `b_data`. op_sel: 0 ADD, 1 SUB, 2 AND, 3 OR. Arithmetic wraps modulo 2^32 with no overflow flag.
- Class precedence at accept:
  - wb_sel=1: memory op. wr_rd=0 is a store (SW); wr_rd=1 is a load (LW). Address = ALU ADD of a_data + operand B.
  - else d_sel=0: MUL. op_sel is ignored. Result is the low 32 bits of a_data*b_data, identical for signed and unsigned.
  - else: ALU op.
- Effective write-back enable is write_back_en && write_back_reg!=0. Writes to r0 are never strobed.
- FSM states: IDLE, MUL, MEM.
  - `in_ready` = (state==IDLE).
  - IDLE & in_valid & ALU: result registered at the accept edge; stay in IDLE.
  - IDLE & in_valid & MUL: go to MUL and load the iteration counter.
  - IDLE & in_valid & mem op: go to MEM with mem_req=1 and latch addr/wdata/we.
  - MUL: after MUL_ITERS cycles, register the product, pulse wb, and go to IDLE.
  - MEM: mem_req, mem_addr, mem_we and mem_wdata are held stable until mem_ack is sampled high. On that edge: mem_req=0; for LW, wb_data=mem_rdata and a wb pulse follows; for SW, no wb. Go to IDLE.
- `mem_ack` is ignored when mem_req=0. `in_valid` is ignored when in_ready=0.
- NOP (ctrl_ex=0xF80) is accepted as an ALU op with no write-back.

## Timing
- All outputs are registered. Reset value of every output is 0 (in_ready=0 is forced while rst is low; in_ready=1 from the first cycle after release). State resets to IDLE.
- ALU: accept at edge N; wb_en high for the cycle after edge N. Back-to-back ALU ops sustain 1 per cycle.
- MUL: accept at edge N; wb_en high for the cycle after edge N+MUL_ITERS. in_ready is low for MUL_ITERS cycles.
- MEM: mem_req rises the cycle after the accept edge. With ack sampled at edge M: mem_req falls after M, LW wb_en pulses the cycle after M, and in_ready is high the cycle after M.
- A new instruction may be accepted in the same cycle a wb_en pulse is visible.
- Reset asserted mid-MUL or mid-MEM: the in-flight op is dropped, mem_req and wb_en drop asynchronously, and no late write-back occurs.

## Structure
- Shared package `control_pkg`:
  - ctrl_ex field bit positions and the 12-bit width.
  - op_sel encodings OP_ADD/OP_SUB/OP_AND/OP_OR.
  - NOP constant 12'hF80.
  - FSM state enum.
- One sub-module: `seq_multiplier`, an iterative shift-add multiplier with start/done, parameterized by MUL_BITS_PER_CYCLE.

## Test plan
- ADD: ctrl_ex=0x4A3, a=5, b=7 -> next cycle wb_en=1, wb_reg=3, wb_data=12. Then SUB 0x5A3, a=3, b=5 on the following cycle -> wb_data=0xFFFFFFFE, with no bubble.
- MUL: ctrl_ex=0x0A4, a=0x10000, b=0x10001 -> in_ready low 8 cycles, then wb_reg=4, wb_data=0x00010000. Second run a=0xFFFFFFFD, b=7 -> 0xFFFFFFEB.
- LW: ctrl_ex=0xCE5, a=0x100, imm=8 -> mem_req=1, mem_addr=0x108, mem_we=0, held stable. Ack after 3 cycles with rdata 0xDEADBEEF -> wb_reg=5, wb_data=0xDEADBEEF.
- SW: ctrl_ex=0xC40, a=0x200, imm=0xFFFFFFFC, b=0x55 -> mem_addr=0x1FC, mem_we=1, mem_wdata=0x55. No wb_en on ack.
- NOP 0xF80 and ADD to r0 (0x4A0) -> no wb_en, in_ready stays 1. Spurious mem_ack in IDLE -> no effect.
- Reset asserted 3 cycles into a MUL, and separately while mem_req is waiting -> all outputs 0 immediately. After release, no wb_en. A following ADD behaves as in the first test.

Source files
------------

// File: rtl/control_pkg.sv
// Shared definitions for the decode -> execute control bundle.
// Holds the ctrl_ex field positions, the op_sel encodings, the NOP word,
// the execute FSM state type and the ALU helper function.
package control_pkg;

  localparam int CTRL_W     = 12;
  localparam int C_SEL_BIT  = 11;  // operand B = imm when set
  localparam int D_SEL_BIT  = 10;  // 0 selects MUL (when not a memory op)
  localparam int OP_HI      = 9;
  localparam int OP_LO      = 8;
  localparam int WR_RD_BIT  = 7;   // memory op: 1 = load, 0 = store
  localparam int WB_SEL_BIT = 6;   // 1 = memory op
  localparam int WBE_BIT    = 5;
  localparam int WBR_HI     = 4;
  localparam int WBR_LO     = 0;

  localparam logic [CTRL_W-1:0] NOP = 12'hF80;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_AND, OP_OR} op_e;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_MEM} state_e;

  function automatic logic [31:0] alu_f(op_e op, logic [31:0] a, logic [31:0] b);
    case (op)
      OP_ADD:  alu_f = a + b;
      OP_SUB:  alu_f = a - b;
      OP_AND:  alu_f = a & b;
      default: alu_f = a | b;
    endcase
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, low 32 bits of a*b.
// Ports: clk/rst (async low), start_i loads operands, done_o is high in the
// cycle whose edge retires the last chunk; prod_o is the accumulator value
// that edge produces, so the consumer registers prod_o when done_o is high.
module seq_multiplier #(
  parameter int MUL_BITS_PER_CYCLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        done_o,
  output logic [31:0] prod_o
);
  localparam int K         = MUL_BITS_PER_CYCLE;
  localparam int MUL_ITERS = 32 / K;

  logic [31:0] acc_q, a_q, b_q, chunk;
  logic [5:0]  cnt_q;

  assign chunk  = 32'(b_q[K-1:0]);
  assign prod_o = acc_q + a_q * chunk;
  assign done_o = (cnt_q == 6'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      acc_q <= '0;
      a_q   <= a_i;
      b_q   <= b_i;
      cnt_q <= 6'(MUL_ITERS);
    end else if (cnt_q != 6'd0) begin
      acc_q <= prod_o;
      a_q   <= a_q << K;
      b_q   <= b_q >> K;
      cnt_q <= cnt_q - 6'd1;
    end
  end
endmodule

// File: rtl/execute_stage.sv
// Execute / memory / write-back stage.
// Ports: in_valid/in_ready handshake with decode (ctrl_ex, a_data, b_data,
// imm); mem_req/mem_we/mem_addr/mem_wdata with mem_ack/mem_rdata toward data
// memory; wb_en/wb_reg/wb_data one-cycle register-file write strobe.
// All outputs registered; rst is asynchronous active-low.
module execute_stage
  import control_pkg::*;
#(
  parameter int MUL_BITS_PER_CYCLE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_ex,
  input  logic [31:0]       a_data,
  input  logic [31:0]       b_data,
  input  logic [31:0]       imm,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              wb_en,
  output logic [4:0]        wb_reg,
  output logic [31:0]       wb_data
);
  state_e      state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic        wb_en_q, wb_en_d;
  logic [4:0]  wb_reg_q, wb_reg_d, pend_reg_q, pend_reg_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        pend_en_q, pend_en_d;  // write-back enable of the op in flight

  logic        accept, is_mem, is_mul, wbe_eff, mul_start, mul_done;
  logic [31:0] opb, mul_prod;
  op_e         op;

  assign op      = op_e'(ctrl_ex[OP_HI:OP_LO]);
  assign opb     = ctrl_ex[C_SEL_BIT] ? imm : b_data;
  assign is_mem  = ctrl_ex[WB_SEL_BIT];
  assign is_mul  = !is_mem && !ctrl_ex[D_SEL_BIT];
  assign wbe_eff = ctrl_ex[WBE_BIT] && (ctrl_ex[WBR_HI:WBR_LO] != 5'd0);
  // in_ready_q is only high in IDLE, so it gates acceptance on its own.
  assign accept    = in_valid && in_ready_q;
  assign mul_start = accept && is_mul;

  seq_multiplier #(.MUL_BITS_PER_CYCLE(MUL_BITS_PER_CYCLE)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start_i (mul_start),
    .a_i     (a_data),
    .b_i     (b_data),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wb_en_d     = 1'b0;
    wb_reg_d    = wb_reg_q;
    wb_data_d   = wb_data_q;
    pend_reg_d  = pend_reg_q;
    pend_en_d   = pend_en_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        pend_reg_d = ctrl_ex[WBR_HI:WBR_LO];
        pend_en_d  = wbe_eff && (!is_mem || ctrl_ex[WR_RD_BIT]);
        if (is_mem) begin
          state_d     = ST_MEM;
          mem_req_d   = 1'b1;
          mem_we_d    = !ctrl_ex[WR_RD_BIT];
          mem_addr_d  = a_data + opb;
          mem_wdata_d = b_data;
        end else if (is_mul) begin
          state_d = ST_MUL;
        end else begin
          wb_en_d   = wbe_eff;
          wb_reg_d  = ctrl_ex[WBR_HI:WBR_LO];
          wb_data_d = alu_f(op, a_data, opb);
        end
      end
      ST_MUL: if (mul_done) begin
        state_d   = ST_IDLE;
        wb_en_d   = pend_en_q;
        wb_reg_d  = pend_reg_q;
        wb_data_d = mul_prod;
      end
      ST_MEM: if (mem_ack) begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        wb_en_d   = pend_en_q;  // stores never set pend_en
        if (pend_en_q) begin
          wb_reg_d  = pend_reg_q;
          wb_data_d = mem_rdata;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wb_en_q     <= 1'b0;
      wb_reg_q    <= '0;
      wb_data_q   <= '0;
      pend_reg_q  <= '0;
      pend_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wb_en_q     <= wb_en_d;
      wb_reg_q    <= wb_reg_d;
      wb_data_q   <= wb_data_d;
      pend_reg_q  <= pend_reg_d;
      pend_en_q   <= pend_en_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_en     = wb_en_q;
  assign wb_reg    = wb_reg_q;
  assign wb_data   = wb_data_q;
endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU, MUL, LW/SW, NOP/r0, spurious ack,
// and asynchronous reset in the middle of MUL and MEM operations.
module tb_execute_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] ctrl_ex = '0;
  logic [31:0] a_data = '0, b_data = '0, imm = '0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  int ncmp = 0;
  int nfail = 0;
  int cnt;
  logic seen;

  execute_stage #(.MUL_BITS_PER_CYCLE(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl_ex(ctrl_ex), .a_data(a_data), .b_data(b_data), .imm(imm),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [11:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] im);
    in_valid = v; ctrl_ex = c; a_data = a; b_data = b; imm = im;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_req"},   32'(mem_req),  32'd0);
    chk({tag, "_we"},    32'(mem_we),   32'd0);
    chk({tag, "_addr"},  mem_addr,      32'd0);
    chk({tag, "_wdata"}, mem_wdata,     32'd0);
    chk({tag, "_wben"},  32'(wb_en),    32'd0);
    chk({tag, "_wbreg"}, 32'(wb_reg),   32'd0);
    chk({tag, "_wbdat"}, wb_data,       32'd0);
  endtask

  task automatic add_sub_test(input string tag);
    drive(1, 12'h4A3, 32'd5, 32'd7, 32'd0);
    step();
    chk({tag, "_add_en"},  32'(wb_en),  32'd1);
    chk({tag, "_add_reg"}, 32'(wb_reg), 32'd3);
    chk({tag, "_add_dat"}, wb_data,     32'd12);
    chk({tag, "_add_rdy"}, 32'(in_ready), 32'd1);
    drive(1, 12'h5A3, 32'd3, 32'd5, 32'd0);
    step();
    chk({tag, "_sub_en"},  32'(wb_en),  32'd1);
    chk({tag, "_sub_dat"}, wb_data,     32'hFFFF_FFFE);
    drive(0, 12'h000, 32'd0, 32'd0, 32'd0);
    step();
    chk({tag, "_idle_en"}, 32'(wb_en),  32'd0);
  endtask

  task automatic mul_test(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    drive(1, 12'h0A4, a, b, 32'd0);
    step();
    drive(0, 12'h000, 32'd0, 32'd0, 32'd0);
    cnt = 0;
    seen = 1'b0;
    while (in_ready === 1'b0 && cnt < 20) begin
      if (wb_en !== 1'b0) seen = 1'b1;
      cnt++;
      step();
    end
    chk("mul_busy_cycles", 32'(cnt), 32'd8);
    chk("mul_early_wb",    32'(seen), 32'd0);
    chk("mul_wb_en",  32'(wb_en),  32'd1);
    chk("mul_wb_reg", 32'(wb_reg), 32'd4);
    chk("mul_wb_dat", wb_data,     exp);
    step();
    chk("mul_wb_pulse", 32'(wb_en), 32'd0);
  endtask

  initial begin
    // reset state
    #12;
    chk_all_zero("rst");
    step();
    rst = 1'b1;
    step();
    chk("ready_after_rel", 32'(in_ready), 32'd1);

    add_sub_test("t1");

    mul_test(32'h0001_0000, 32'h0001_0001, 32'h0001_0000);
    mul_test(32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB);

    // LW, ack after 3 waiting cycles
    drive(1, 12'hCE5, 32'h100, 32'h0, 32'd8);
    step();
    drive(0, 12'h000, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("lw_req",   32'(mem_req),  32'd1);
      chk("lw_addr",  mem_addr,      32'h108);
      chk("lw_we",    32'(mem_we),   32'd0);
      chk("lw_rdy",   32'(in_ready), 32'd0);
      if (i < 2) step();
    end
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    chk("lw_req_fall", 32'(mem_req),  32'd0);
    chk("lw_wb_en",    32'(wb_en),    32'd1);
    chk("lw_wb_reg",   32'(wb_reg),   32'd5);
    chk("lw_wb_dat",   wb_data,       32'hDEAD_BEEF);
    chk("lw_rdy",      32'(in_ready), 32'd1);

    // SW, acked immediately
    drive(1, 12'hC40, 32'h200, 32'h55, 32'hFFFF_FFFC);
    step();
    drive(0, 12'h000, 32'd0, 32'd0, 32'd0);
    chk("sw_req",   32'(mem_req), 32'd1);
    chk("sw_addr",  mem_addr,     32'h1FC);
    chk("sw_we",    32'(mem_we),  32'd1);
    chk("sw_wdata", mem_wdata,    32'h55);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("sw_req_fall", 32'(mem_req), 32'd0);
    chk("sw_no_wb",    32'(wb_en),   32'd0);
    chk("sw_wb_hold",  wb_data,      32'hDEAD_BEEF);
    step();
    chk("sw_no_wb2",   32'(wb_en),   32'd0);

    // NOP then ADD to r0
    drive(1, 12'hF80, 32'h1, 32'h2, 32'h3);
    step();
    chk("nop_wb",  32'(wb_en),    32'd0);
    chk("nop_rdy", 32'(in_ready), 32'd1);
    drive(1, 12'h4A0, 32'd5, 32'd7, 32'd0);
    step();
    drive(0, 12'h000, 32'd0, 32'd0, 32'd0);
    chk("r0_wb",  32'(wb_en),    32'd0);
    chk("r0_rdy", 32'(in_ready), 32'd1);

    // spurious ack in IDLE
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mem_ack = 1'b0;
    chk("spur_req", 32'(mem_req), 32'd0);
    chk("spur_wb",  32'(wb_en),   32'd0);
    step();
    chk("spur_wb2", 32'(wb_en),   32'd0);
    chk("spur_rdy", 32'(in_ready), 32'd1);

    // reset three cycles into a MUL
    drive(1, 12'h0A4, 32'd3, 32'd3, 32'd0);
    step();
    drive(0, 12'h000, 32'd0, 32'd0, 32'd0);
    step(); step();
    #1 rst = 1'b0;
    #1 chk_all_zero("rst_mul");
    step();
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (wb_en !== 1'b0) seen = 1'b1;
    end
    chk("rst_mul_no_late_wb", 32'(seen), 32'd0);
    add_sub_test("t2");

    // reset while mem_req waits
    drive(1, 12'hCE5, 32'h100, 32'h0, 32'd8);
    step();
    drive(0, 12'h000, 32'd0, 32'd0, 32'd0);
    chk("rst_mem_pre_req", 32'(mem_req), 32'd1);
    step();
    #1 rst = 1'b0;
    #1 chk_all_zero("rst_mem");
    step();
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (wb_en !== 1'b0 || mem_req !== 1'b0) seen = 1'b1;
    end
    chk("rst_mem_quiet", 32'(seen), 32'd0);
    add_sub_test("t3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
